// File: rtl/divider_feeder.sv
// Operand-queueing front end for the 8-bit sequential divider: buffers (N, D)
// pairs, issues one job at a time, and returns quotient/remainder in order.
module divider_feeder #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       reset,
  // operand stream
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_N,
  input  logic [7:0] in_D,
  // result stream
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_Q,
  output logic [7:0] res_R,
  output logic       res_dz,
  output logic       busy,
  // divider handshake
  output logic       div_start,
  output logic [7:0] div_N,
  output logic [7:0] div_D,
  input  logic       div_idle,
  input  logic       div_finish,
  input  logic [7:0] div_Q,
  input  logic [7:0] div_R
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } state_t;

  state_t        state_reg, state_next;

  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [7:0]    head_n, head_d;
  logic          fifo_empty;
  logic          push, pop;

  logic          res_valid_reg;
  logic [7:0]    res_q_reg, res_r_reg;
  logic          res_dz_reg;
  logic          slot_free;
  logic          slot_wr;
  logic [7:0]    slot_q, slot_r;
  logic          slot_dz;

  logic [7:0]    div_n_reg, div_d_reg;
  logic          load_op;

  // ------------------------------------------------------------------
  // Operand FIFO
  // ------------------------------------------------------------------
  assign in_ready   = (count_reg != FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  assign push       = in_valid & in_ready;

  // The head must be visible the cycle after a push, so the small array is
  // read asynchronously (distributed RAM rather than a block RAM).
  assign {head_n, head_d} = fifo_mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_N, in_D};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Issue FSM
  // ------------------------------------------------------------------
  assign slot_free = !res_valid_reg | res_ready;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load_op    = 1'b0;
    slot_wr    = 1'b0;
    slot_q     = div_Q;
    slot_r     = div_R;
    slot_dz    = 1'b0;
    div_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && slot_free) begin
          if (head_d == 8'd0) begin
            // Divide-by-zero never reaches the divider.
            pop     = 1'b1;
            slot_wr = 1'b1;
            slot_q  = 8'hFF;
            slot_r  = head_n;
            slot_dz = 1'b1;
          end else if (div_idle) begin
            pop        = 1'b1;
            load_op    = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        div_start  = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        // Only one job is ever outstanding, so the slot is empty here.
        if (div_finish) begin
          slot_wr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // Operand registers held for the whole divider job
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      div_n_reg <= 8'd0;
      div_d_reg <= 8'd0;
    end else if (load_op) begin
      div_n_reg <= head_n;
      div_d_reg <= head_d;
    end
  end

  assign div_N = div_n_reg;
  assign div_D = div_d_reg;

  // ------------------------------------------------------------------
  // Result slot
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      res_valid_reg <= 1'b0;
      res_q_reg     <= 8'd0;
      res_r_reg     <= 8'd0;
      res_dz_reg    <= 1'b0;
    end else if (slot_wr) begin
      res_valid_reg <= 1'b1;
      res_q_reg     <= slot_q;
      res_r_reg     <= slot_r;
      res_dz_reg    <= slot_dz;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_Q     = res_q_reg;
  assign res_R     = res_r_reg;
  assign res_dz    = res_dz_reg;

  assign busy = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_divider_feeder.sv
// Directed bench for divider_feeder: a stub divider, an in-order result
// scoreboard, protocol checks every cycle and hand-computed literal results.
module tb_divider_feeder;

  localparam int DEPTH = 4;
  localparam int LAT   = 5;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_N = 8'd0;
  logic [7:0] in_D = 8'd0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_Q, res_R;
  logic       res_dz;
  logic       busy;
  logic       div_start;
  logic [7:0] div_N, div_D;
  logic       div_idle, div_finish;
  logic [7:0] div_Q, div_R;

  logic       stub_busy, stub_finish;
  logic       inject_finish = 1'b0;
  int         stub_cnt;
  logic [7:0] stub_n, stub_d;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];

  logic       hold_prev = 1'b0;
  logic [7:0] prev_q, prev_r;
  logic       prev_dz;

  divider_feeder #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_N      (in_N),
    .in_D      (in_D),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_Q     (res_Q),
    .res_R     (res_R),
    .res_dz    (res_dz),
    .busy      (busy),
    .div_start (div_start),
    .div_N     (div_N),
    .div_D     (div_D),
    .div_idle  (div_idle),
    .div_finish(div_finish),
    .div_Q     (div_Q),
    .div_R     (div_R)
  );

  always #5 CLK = ~CLK;

  // Stub sequential divider: fixed latency, shares the feeder's reset.
  always @(posedge CLK) begin
    if (reset) begin
      stub_busy   <= 1'b0;
      stub_finish <= 1'b0;
      stub_cnt    <= 0;
      stub_n      <= 8'd0;
      stub_d      <= 8'd0;
      div_Q       <= 8'd0;
      div_R       <= 8'd0;
    end else begin
      stub_finish <= 1'b0;
      if (div_start && !stub_busy) begin
        stub_busy <= 1'b1;
        stub_cnt  <= LAT;
        stub_n    <= div_N;
        stub_d    <= div_D;
      end else if (stub_busy) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_busy   <= 1'b0;
          stub_finish <= 1'b1;
          div_Q       <= (stub_d == 8'd0) ? 8'hFF : stub_n / stub_d;
          div_R       <= (stub_d == 8'd0) ? stub_n : stub_n % stub_d;
        end
      end
    end
  end

  assign div_idle   = !stub_busy && !stub_finish;
  assign div_finish = stub_finish | inject_finish;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input logic cond);
    chk(name, {31'd0, cond}, 32'd1);
  endtask

  function automatic res_t model(input logic [7:0] n, input logic [7:0] d);
    res_t e;
    if (d == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = n;
      e.dz = 1'b1;
    end else begin
      e.q  = n / d;
      e.r  = n % d;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard and per-cycle protocol checks.
  always @(negedge CLK) begin
    if (reset) begin
      exp_q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_N, in_D));
      end
      if (div_start) begin
        n_starts <= n_starts + 1;
        chk_true("start_needs_idle", div_idle);
        chk_true("start_nonzero_D", div_D != 8'd0);
      end
      if (stub_busy) begin
        chk("div_N_held", div_N, stub_n);
        chk("div_D_held", div_D, stub_d);
      end
      if (hold_prev) begin
        chk("res_valid_held", res_valid, 1);
        chk("res_Q_held", res_Q, prev_q);
        chk("res_R_held", res_R, prev_r);
        chk("res_dz_held", res_dz, prev_dz);
      end
      if (res_valid && res_ready) begin
        got_q.push_back('{q: res_Q, r: res_R, dz: res_dz});
        if (exp_q.size() == 0) begin
          chk_true("unexpected_result", 1'b0);
        end else begin
          chk("res_Q", res_Q, exp_q[0].q);
          chk("res_R", res_R, exp_q[0].r);
          chk("res_dz", res_dz, exp_q[0].dz);
          exp_q.delete(0);
        end
      end
      hold_prev <= res_valid && !res_ready;
      prev_q    <= res_Q;
      prev_r    <= res_R;
      prev_dz   <= res_dz;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic push(input logic [7:0] n, input logic [7:0] d);
    int w = 0;
    in_N     = n;
    in_D     = d;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk_true("push_accept", in_ready);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Called at a negedge.
  task automatic wait_res(input int bound);
    int w = 0;
    while (!res_valid && w < bound) begin
      @(negedge CLK);
      w++;
    end
    chk_true("res_timeout", res_valid);
  endtask

  task automatic wait_drain(input int bound);
    int w = 0;
    while (exp_q.size() != 0 && w < bound) begin
      @(negedge CLK);
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_Q"}, res_Q, 0);
    chk({tag, "_res_R"}, res_R, 0);
    chk({tag, "_res_dz"}, res_dz, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_div_N"}, div_N, 0);
    chk({tag, "_div_D"}, div_D, 0);
  endtask

  logic [7:0] fill_q  [6] = '{8'd66, 8'd255, 8'd1, 8'd0, 8'd0, 8'd255};
  logic [7:0] fill_r  [6] = '{8'd2, 8'd9, 8'd0, 8'd8, 8'd1, 8'd99};
  logic       fill_dz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int s0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;

    // Single job: 100 / 7
    push(8'd100, 8'd7);
    @(negedge CLK);
    chk("job_start_t1", div_start, 0);
    @(negedge CLK);
    chk("job_start_t2", div_start, 1);
    chk("job_div_N", div_N, 100);
    chk("job_div_D", div_D, 7);
    @(negedge CLK);
    chk("job_start_t3", div_start, 0);
    wait_res(50);
    chk("job_Q", res_Q, 14);
    chk("job_R", res_R, 2);
    chk("job_dz", res_dz, 0);
    @(posedge CLK);
    #1;

    // Divide-by-zero bypass: 55 / 0
    s0 = n_starts;
    push(8'd55, 8'd0);
    @(negedge CLK);
    chk("dz_valid_t1", res_valid, 0);
    @(negedge CLK);
    chk("dz_valid_t2", res_valid, 1);
    chk("dz_Q", res_Q, 255);
    chk("dz_R", res_R, 55);
    chk("dz_flag", res_dz, 1);
    repeat (4) @(negedge CLK);
    chk("dz_no_start", n_starts, s0);
    @(posedge CLK);
    #1;

    // Fill and ordering with the consumer stalled
    got_q.delete();
    res_ready = 1'b0;
    push(8'd200, 8'd3);
    push(8'd9, 8'd0);
    push(8'd17, 8'd17);
    push(8'd8, 8'd9);
    push(8'd1, 8'd2);
    @(negedge CLK);
    chk("fill_full", in_ready, 0);
    fork
      push(8'd99, 8'd0);
      begin
        repeat (12) @(negedge CLK);
        chk("fill_stall", in_ready, 0);
        chk("fill_pending_valid", res_valid, 1);
        chk("fill_pending_Q", res_Q, 66);
        chk("fill_pending_R", res_R, 2);
        @(posedge CLK);
        #1 res_ready = 1'b1;
      end
    join
    @(negedge CLK);
    wait_drain(200);
    chk("fill_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("fill_Q%0d", i), got_q[i].q, fill_q[i]);
        chk($sformatf("fill_R%0d", i), got_q[i].r, fill_r[i]);
        chk($sformatf("fill_dz%0d", i), got_q[i].dz, fill_dz[i]);
      end
    end
    @(posedge CLK);
    #1;

    // Backpressure: pending bypass result blocks the next issue
    got_q.delete();
    res_ready = 1'b0;
    s0 = n_starts;
    push(8'd40, 8'd0);
    push(8'd50, 8'd5);
    repeat (10) @(negedge CLK);
    chk("bp_no_start", n_starts, s0);
    chk("bp_pending_Q", res_Q, 255);
    chk("bp_pending_R", res_R, 40);
    @(posedge CLK);
    #1 res_ready = 1'b1;
    @(negedge CLK);
    wait_drain(100);
    chk("bp_one_start", n_starts, s0 + 1);
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_Q", got_q[1].q, 10);
      chk("bp_R", got_q[1].r, 0);
      chk("bp_dz", got_q[1].dz, 0);
    end
    @(posedge CLK);
    #1;

    // Reset mid-job, then a stale finish
    got_q.delete();
    res_ready = 1'b0;
    push(8'd250, 8'd3);
    push(8'd30, 8'd4);
    begin
      int w = 0;
      @(negedge CLK);
      while (!stub_busy && w < 50) begin
        @(negedge CLK);
        w++;
      end
      chk_true("rst_job_started", stub_busy);
    end
    @(posedge CLK);
    #1 reset = 1'b1;
    @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    s0 = n_starts;
    @(posedge CLK);
    #1 inject_finish = 1'b1;
    @(posedge CLK);
    #1 inject_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stale_res_valid", res_valid, 0);
    end
    chk("stale_busy", busy, 0);
    chk("stale_no_start", n_starts, s0);
    @(posedge CLK);
    #1 res_ready = 1'b1;

    // Recovery after reset: 21 / 4
    push(8'd21, 8'd4);
    @(negedge CLK);
    wait_res(50);
    chk("recover_Q", res_Q, 5);
    chk("recover_R", res_R, 1);
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
